// File: rtl/tick_scheduler_pkg.sv
// Shared sizing helpers for clock-enable generators built around a common prescaler.
package tick_scheduler_pkg;

  // Bits needed to index or count n states; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a prescaler that counts 0..prescale-1.
  function automatic int prescale_width(input int prescale);
    return idx_width(prescale);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: holds its period in base ticks and fires a registered
// one-cycle enable when its down-counter reaches zero on a base tick.
module tick_channel #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                base_tick,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_period,
  output logic                tick,
  output logic                active
);

  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic                tick_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg <= '0;
      count_reg  <= '0;
      tick_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (base_tick) begin
        // A retimed channel restarts its count and stays quiet on the load boundary.
        if (load) begin
          period_reg <= load_period;
          count_reg  <= (load_period == '0) ? '0 : load_period - PERIOD_W'(1);
        end else if (period_reg != '0) begin
          if (count_reg == '0) begin
            tick_reg  <= 1'b1;
            count_reg <= period_reg - PERIOD_W'(1);
          end else begin
            count_reg <= count_reg - PERIOD_W'(1);
          end
        end
      end
    end
  end

  assign tick   = tick_reg;
  assign active = (period_reg != '0);

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler driving NUM_CH programmable tick channels; a single-entry
// pending slot holds one config write until the next base-tick boundary.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int  PRESCALE = 12,
  parameter int  NUM_CH   = 4,
  parameter int  PERIOD_W = 8,
  localparam int CH_W     = idx_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   tick_out,
  output logic [NUM_CH-1:0]   ch_active
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc_reg;
  logic [PW-1:0]       presc_next;
  logic                base_tick_reg;
  logic                pending_reg;
  logic [CH_W-1:0]     pend_ch_reg;
  logic [PERIOD_W-1:0] pend_period_reg;
  logic                cfg_fire;
  logic                apply;

  always_comb begin
    presc_next = presc_reg + PW'(1);
    if (presc_reg == LAST) begin
      presc_next = '0;
    end
  end

  assign cfg_ready = ~pending_reg;
  assign cfg_fire  = cfg_valid & ~pending_reg;
  assign apply     = base_tick_reg & pending_reg;

  // base_tick is registered from the next prescaler value so it lines up with presc_reg == LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg       <= '0;
      base_tick_reg   <= 1'b0;
      pending_reg     <= 1'b0;
      pend_ch_reg     <= '0;
      pend_period_reg <= '0;
    end else begin
      presc_reg     <= presc_next;
      base_tick_reg <= (presc_next == LAST);
      if (apply) begin
        pending_reg <= 1'b0;
      end else if (cfg_fire) begin
        pending_reg     <= 1'b1;
        pend_ch_reg     <= cfg_ch;
        pend_period_reg <= cfg_period;
      end
    end
  end

  assign base_tick = base_tick_reg;

  // Out-of-range channel indices match no channel, so such writes drain harmlessly.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tick_channel #(
        .PERIOD_W(PERIOD_W)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .base_tick   (base_tick_reg),
        .load        (apply && (pend_ch_reg == CH_W'(gi))),
        .load_period (pend_period_reg),
        .tick        (tick_out[gi]),
        .active      (ch_active[gi])
      );
    end
  endgenerate

endmodule
